// File: rtl/fast_pkg.sv
// fast_pkg: FAST field-op encoding, datatype/operator enums and per-datatype byte limits shared with the op scheduler
package fast_pkg;
  typedef enum logic [1:0] {DT_U32, DT_I32, DT_U64, DT_I64} datatype_e;
  typedef enum logic [1:0] {OP_NONE, OP_CONST, OP_COPY, OP_INCR} operator_e;
  localparam int FO_NUM_LSB = 0;
  localparam int FO_DT_LSB = 4;
  localparam int FO_OPR_LSB = 6;
  localparam int FO_OPT_BIT = 8;
  localparam int FO_PMAP_BIT = 9;
  localparam int FO_CONST_LSB = 10;
  localparam int LIMIT_32 = 5;
  localparam int LIMIT_64 = 10;
  typedef struct packed {
    logic [21:0] const_val;
    logic pmap;
    logic optional;
    operator_e opr;
    datatype_e dt;
    logic [3:0] num;
  } field_op_t;
  function automatic logic [3:0] byte_limit(datatype_e dt);
    return dt[1] ? 4'(LIMIT_64) : 4'(LIMIT_32);
  endfunction
endpackage

// File: rtl/fast_field_decoder_if.sv
// fast_field_decoder_if: op issue/complete, dictionary clear and beat stream between scheduler and decode lane
interface fast_field_decoder_if #(
  parameter int beat_width = 64,
  parameter int field_op_size = 32,
  parameter int value_width = 64
);
  logic op_valid;
  logic op_ready;
  logic [field_op_size-1:0] field_op;
  logic dict_clear;
  logic beat_valid;
  logic beat_ready;
  logic [beat_width-1:0] beat_data;
  logic [$clog2(beat_width/8):0] beat_bytes;
  logic field_complete;
  logic [3:0] field_num;
  logic [value_width-1:0] field_value;
  logic field_null;
  logic field_error;
  modport master (
    output op_valid, field_op, dict_clear, beat_valid, beat_data, beat_bytes,
    input op_ready, beat_ready, field_complete, field_num, field_value, field_null, field_error
  );
  modport slave (
    input op_valid, field_op, dict_clear, beat_valid, beat_data, beat_bytes,
    output op_ready, beat_ready, field_complete, field_num, field_value, field_null, field_error
  );
endinterface

// File: rtl/fast_byte_unpacker.sv
// fast_byte_unpacker: one-beat buffer handing out its valid bytes one per cycle, byte 0 first
module fast_byte_unpacker #(
  parameter int beat_width = 64
) (
  input logic clk,
  input logic rstn,
  input logic beat_valid,
  input logic [beat_width-1:0] beat_data,
  input logic [$clog2(beat_width/8):0] beat_bytes,
  output logic beat_ready,
  output logic byte_valid,
  output logic [7:0] byte_data,
  input logic byte_take
);
  logic [beat_width-1:0] buf_q;
  logic [$clog2(beat_width/8):0] left;
  assign beat_ready = left == '0;
  assign byte_valid = !beat_ready;
  assign byte_data = buf_q[7:0];
  // shifting the beat down stands in for a byte pointer into it
  always_ff @(posedge clk)
    if (!rstn) begin
      left <= '0;
      buf_q <= '0;
    end else if (beat_valid && beat_ready) begin
      buf_q <= beat_data;
      left <= beat_bytes;
    end else if (byte_take && byte_valid) begin
      buf_q <= buf_q >> 8;
      left <= left - 1'b1;
    end
endmodule

// File: rtl/fast_field_decoder.sv
// fast_field_decoder: one FAST field-decode lane applying none/constant/copy/increment against a per-field dictionary
module fast_field_decoder
  import fast_pkg::*;
#(
  parameter int beat_width = 64,
  parameter int max_message_size = 10,
  parameter int value_width = 64
) (
  input logic clk,
  input logic rstn,
  fast_field_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DECODE, RESOLVE, DONE} state_e;
  state_e state, next;
  field_op_t op;
  operator_e in_opr;
  logic [value_width-1:0] dict [max_message_size];
  logic [max_message_size-1:0] defined;
  logic [value_width-1:0] acc, acc_next, cur, inc, res_value;
  logic [3:0] nbytes;
  logic [7:0] byte_data;
  logic byte_valid, byte_take, load, res_null, res_error, hit, known, nullable, stop, last, write;
  fast_byte_unpacker #(.beat_width(beat_width)) u_unpacker (
    .clk,
    .rstn,
    .beat_valid(bus.beat_valid),
    .beat_data(bus.beat_data),
    .beat_bytes(bus.beat_bytes),
    .beat_ready(bus.beat_ready),
    .byte_valid,
    .byte_data,
    .byte_take
  );
  assign bus.op_ready = state == IDLE;
  assign bus.field_complete = state == DONE;
  assign in_opr = operator_e'(bus.field_op[FO_OPR_LSB +: 2]);
  assign hit = 32'(op.num) < max_message_size;
  assign known = hit && defined[op.num];
  assign cur = hit ? dict[op.num] : '0;
  assign inc = (cur + value_width'(1)) & (op.dt[1] ? '1 : value_width'(32'hFFFF_FFFF));
  // the accumulator is zero on the first byte, so only the sign fill needs special casing
  assign acc_next = {(nbytes == 4'd0 && op.dt[0] && byte_data[6]) ? {(value_width-7){1'b1}} : acc[value_width-8:0], byte_data[6:0]};
  assign stop = byte_data[7];
  assign last = stop || nbytes + 4'd1 == byte_limit(op.dt);
  assign nullable = op.optional && op.opr != OP_CONST;
  assign write = state == DONE && !bus.field_null && !bus.field_error && op.opr != OP_CONST && hit;
  always_comb begin
    next = state;
    byte_take = 1'b0;
    load = 1'b0;
    res_null = 1'b0;
    res_error = 1'b0;
    res_value = '0;
    case (state)
      IDLE: if (bus.op_valid) next = in_opr == OP_NONE || (in_opr != OP_CONST && bus.field_op[FO_PMAP_BIT]) ? DECODE : RESOLVE;
      RESOLVE: begin
        next = DONE;
        load = 1'b1;
        res_null = op.opr == OP_CONST && op.optional && !op.pmap;
        res_error = op.opr != OP_CONST && !known;
        res_value = res_null || res_error ? '0 : op.opr == OP_CONST ? value_width'(op.const_val) : op.opr == OP_COPY ? cur : inc;
      end
      DECODE: if (byte_valid) begin
        byte_take = 1'b1;
        next = last ? DONE : DECODE;
        load = last;
        res_error = !stop;
        res_null = stop && nullable && acc_next == '0;
        res_value = !stop || res_null ? '0 : nullable && !(op.dt[0] && acc_next[value_width-1]) ? acc_next - value_width'(1) : acc_next;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      op <= '0;
      acc <= '0;
      nbytes <= '0;
      defined <= '0;
      bus.field_num <= '0;
      bus.field_value <= '0;
      bus.field_null <= 1'b0;
      bus.field_error <= 1'b0;
    end else begin
      state <= next;
      if (bus.op_valid && bus.op_ready) begin
        op <= bus.field_op;
        acc <= '0;
        nbytes <= '0;
      end
      if (byte_take) begin
        acc <= acc_next;
        nbytes <= nbytes + 4'd1;
      end
      if (load) begin
        bus.field_num <= op.num;
        bus.field_value <= res_value;
        bus.field_null <= res_null;
        bus.field_error <= res_error;
      end
      if (bus.dict_clear) defined <= '0;
      else if (write) defined[op.num] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (rstn && write) dict[op.num] <= bus.field_value;
endmodule

// File: tb/tb_fast_field_decoder.sv
// tb_fast_field_decoder: directed test-plan cases plus randomized ops against a byte-queue/dictionary reference model
module tb_fast_field_decoder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  fast_field_decoder_if bus();
  fast_field_decoder dut(.clk(clk), .rstn(rstn), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int beat_max = 8;
  int gap = 0;
  bit rnd_feed = 1'b0;
  logic [7:0] tx[$];
  logic [7:0] mq[$];
  logic [63:0] mdict [10];
  logic [9:0] mdef = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx.push_back(b);
    mq.push_back(b);
  endtask

  task automatic feed();
    int k;
    logic [63:0] d;
    bus.beat_valid = 1'b0;
    if (!rstn || !bus.beat_ready || tx.size() == 0) return;
    if (gap > 0) begin
      gap--;
      return;
    end
    if (rnd_feed && $urandom_range(0, 3) == 0) return;
    k = tx.size() < beat_max ? tx.size() : beat_max;
    if (rnd_feed) k = $urandom_range(1, k);
    d = '0;
    for (int i = 0; i < k; i++) d[8*i +: 8] = tx.pop_front();
    bus.beat_data = d;
    bus.beat_bytes = 4'(k);
    bus.beat_valid = 1'b1;
  endtask

  task automatic tick();
    feed();
    step();
  endtask

  function automatic logic [31:0] fop(input int num, input int dt, input int opr, input int opt, input int pmap, input int cv);
    return {22'(cv), 1'(pmap), 1'(opt), 2'(opr), 2'(dt), 4'(num)};
  endfunction

  // value of the field as the wire defines it: base-128 digits, two's complement over 7*n bits when signed
  function automatic void model(input logic [31:0] fo, output logic [63:0] v, output logic nul, output logic err);
    logic [3:0] num;
    logic [1:0] dt, opr;
    logic opt, pmap, neg, stop;
    logic [7:0] b;
    logic [63:0] u;
    int n, lim;
    {pmap, opt, opr, dt, num} = fo[9:0];
    lim = dt[1] ? 10 : 5;
    v = '0;
    nul = 1'b0;
    err = 1'b0;
    if (opr == 2'd1) begin
      nul = opt && !pmap;
      v = nul ? 64'd0 : 64'(fo[31:10]);
    end else if (opr != 2'd0 && !pmap) begin
      if (!mdef[num]) err = 1'b1;
      else if (opr == 2'd2) v = mdict[num];
      else v = dt[1] ? mdict[num] + 64'd1 : (mdict[num] + 64'd1) % 64'h1_0000_0000;
    end else begin
      n = 0;
      u = '0;
      stop = 1'b0;
      neg = 1'b0;
      while (!stop && n < lim) begin
        b = mq.pop_front();
        if (n == 0) neg = dt[0] && b[6];
        u = u * 64'd128 + 64'(b[6:0]);
        n++;
        stop = b[7];
      end
      if (!stop) err = 1'b1;
      else begin
        if (neg && 7 * n < 64) u = u - (64'd1 << (7 * n));
        if (opt && u == 64'd0) nul = 1'b1;
        else v = (opt && (!dt[0] || $signed(u) > 0)) ? u - 64'd1 : u;
      end
    end
    if (!nul && !err && opr != 2'd1) begin
      mdict[num] = v;
      mdef[num] = 1'b1;
    end
  endfunction

  task automatic run_op(input logic [31:0] fo, output int lat);
    chk("op_ready_idle", 64'(bus.op_ready), 64'd1);
    bus.op_valid = 1'b1;
    bus.field_op = fo;
    tick();
    bus.op_valid = 1'b0;
    lat = 1;
    chk("op_ready_busy", 64'(bus.op_ready), 64'd0);
    while (!bus.field_complete && lat < 300) begin
      tick();
      lat++;
    end
    chk("complete", 64'(bus.field_complete), 64'd1);
  endtask

  task automatic issue(input string tag, input logic [31:0] fo, input int exp_lat);
    logic [63:0] v;
    logic nul, err;
    int lat;
    model(fo, v, nul, err);
    run_op(fo, lat);
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_num"}, 64'(bus.field_num), 64'(fo[3:0]));
    chk({tag, "_value"}, bus.field_value, v);
    chk({tag, "_null"}, 64'(bus.field_null), 64'(nul));
    chk({tag, "_error"}, 64'(bus.field_error), 64'(err));
  endtask

  task automatic finish_op(input logic clr);
    bus.dict_clear = clr;
    tick();
    bus.dict_clear = 1'b0;
    chk("complete_pulse", 64'(bus.field_complete), 64'd0);
    if (clr) mdef = '0;
  endtask

  task automatic gen_bytes(input logic [1:0] dt);
    int n, lim;
    lim = dt[1] ? 10 : 5;
    case ($urandom_range(0, 9))
      0: for (int i = 0; i < lim; i++) push(8'($urandom_range(0, 127)));
      1: push(8'h80);
      default: begin
        n = $urandom_range(1, lim - 1);
        for (int i = 0; i < n; i++) push(8'($urandom_range(0, 127)) | (i == n - 1 ? 8'h80 : 8'h00));
      end
    endcase
  endtask

  initial begin
    logic [31:0] fo;
    bus.op_valid = 1'b0;
    bus.field_op = '0;
    bus.dict_clear = 1'b0;
    bus.beat_valid = 1'b0;
    bus.beat_data = '0;
    bus.beat_bytes = '0;
    repeat (3) step();
    chk("rst_op_ready", 64'(bus.op_ready), 64'd1);
    chk("rst_beat_ready", 64'(bus.beat_ready), 64'd1);
    chk("rst_complete", 64'(bus.field_complete), 64'd0);
    chk("rst_value", bus.field_value, 64'd0);
    chk("rst_flags", {61'd0, bus.field_null, bus.field_error, 1'b0}, 64'd0);
    rstn = 1'b1;
    step();
    push(8'h39); push(8'h45); push(8'hA3);
    tick();
    issue("u32_3byte", fop(3, 0, 0, 0, 0, 0), 4);
    chk("u32_3byte_const", bus.field_value, 64'hE62A3);
    chk("u32_3byte_beat_ready", 64'(bus.beat_ready), 64'd1);
    finish_op(1'b0);
    push(8'hFF);
    issue("i32_neg", fop(5, 1, 0, 0, 0, 0), 2);
    chk("i32_neg_const", bus.field_value, 64'hFFFF_FFFF_FFFF_FFFF);
    finish_op(1'b0);
    push(8'h80);
    issue("opt_null", fop(6, 0, 0, 1, 0, 0), 2);
    chk("opt_null_const", 64'(bus.field_null), 64'd1);
    finish_op(1'b0);
    issue("copy", fop(3, 0, 2, 0, 0, 0), 2);
    chk("copy_const", bus.field_value, 64'hE62A3);
    finish_op(1'b0);
    issue("incr", fop(3, 0, 3, 0, 0, 0), 2);
    chk("incr_const", bus.field_value, 64'hE62A4);
    finish_op(1'b0);
    beat_max = 2;
    push(8'h01); push(8'h02); push(8'h83);
    tick();
    gap = 3;
    issue("span", fop(7, 0, 0, 0, 0, 0), 5 + 3);
    chk("span_const", bus.field_value, 64'h4103);
    finish_op(1'b0);
    beat_max = 8;
    issue("const_null", fop(4, 0, 1, 1, 0, 123), 2);
    finish_op(1'b0);
    issue("const_val", fop(4, 0, 1, 0, 0, 22'h3FFFFF), 2);
    chk("const_val_const", bus.field_value, 64'h3FFFFF);
    finish_op(1'b0);
    for (int i = 1; i <= 5; i++) push(8'(i));
    push(8'h86);
    issue("overlong", fop(0, 0, 0, 0, 0, 0), 6);
    chk("overlong_const", 64'(bus.field_error), 64'd1);
    chk("overlong_leftover", 64'(bus.beat_ready), 64'd0);
    finish_op(1'b0);
    issue("leftover", fop(1, 0, 0, 0, 0, 0), 2);
    chk("leftover_const", bus.field_value, 64'd6);
    finish_op(1'b0);
    push(8'h01); push(8'h02); push(8'h83);
    bus.op_valid = 1'b1;
    bus.field_op = fop(2, 0, 0, 0, 0, 0);
    tick();
    bus.op_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_complete", 64'(bus.field_complete), 64'd0);
    end
    chk("midrst_op_ready", 64'(bus.op_ready), 64'd1);
    chk("midrst_beat_ready", 64'(bus.beat_ready), 64'd1);
    chk("midrst_value", bus.field_value, 64'd0);
    rstn = 1'b1;
    tx.delete();
    mq.delete();
    mdef = '0;
    step();
    push(8'h81);
    issue("post_rst", fop(3, 0, 0, 0, 0, 0), 2);
    finish_op(1'b0);
    issue("copy_defined", fop(3, 0, 2, 0, 0, 0), 2);
    finish_op(1'b0);
    bus.dict_clear = 1'b1;
    tick();
    bus.dict_clear = 1'b0;
    mdef = '0;
    issue("copy_cleared", fop(3, 0, 2, 0, 0, 0), 2);
    chk("copy_cleared_const", 64'(bus.field_error), 64'd1);
    finish_op(1'b0);
    push(8'h85);
    issue("clear_collide", fop(3, 0, 0, 0, 0, 0), 2);
    finish_op(1'b1);
    issue("copy_after_collide", fop(3, 0, 2, 0, 0, 0), 2);
    chk("copy_after_collide_const", 64'(bus.field_error), 64'd1);
    finish_op(1'b0);
    rnd_feed = 1'b1;
    for (int t = 0; t < 150; t++) begin
      fo = fop($urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), int'($urandom));
      if (fo[7:6] == 2'd0 || (fo[7:6] != 2'd1 && fo[9])) gen_bytes(fo[5:4]);
      issue("rnd", fo, 0);
      finish_op($urandom_range(0, 15) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
